csel_sub_seq: RTL
=================

CSEL_SUB_SEQ -- requirements
Module: csel_sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; must be a multiple of SLICE.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per cycle; NSLICE = WIDTH/SLICE.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a subtraction; sampled only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-010 SHALL have port bout  output  1  borrow-out; 1 when unsigned a < b + bin.
REQ-011 SHALL have port ovf  output  1  two's-complement signed overflow of the subtraction.
REQ-012 SHALL have port busy  output  1  high in RUN and DONE.
REQ-013 SHALL have port done  output  1  one-cycle pulse; d/bout/ovf valid.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE with start=1, the edge SHALL latch a, b, bin into internal registers, set slice index to 0, and move to RUN.
REQ-016 In IDLE with start=0, state and all outputs SHALL hold.
REQ-017 In RUN, each edge SHALL compute slice idx (bits idx*SLICE+SLICE-1 : idx*SLICE) twice in parallel, once with borrow-in 0 and once with borrow-in 1.
REQ-018 The registered running borrow SHALL select the difference and borrow-out of that slice (borrow-select); the selected difference is written to d, the selected borrow becomes the running borrow, and idx increments.
REQ-019 After slice NSLICE-1, RUN SHALL go to DONE; bout SHALL equal the final running borrow.
REQ-020 ovf SHALL be set at the last slice as (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]) using latched operands.
REQ-021 done SHALL be high exactly in the DONE cycle, i.e. NSLICE edges after the edge accepting start (4 for defaults); DONE SHALL go to IDLE on the next edge.
REQ-022 start in RUN or DONE SHALL be ignored; the in-flight operation completes unaffected, and changes on a/b/bin after acceptance SHALL have no effect.
REQ-023 d, bout, ovf SHALL hold their last result from DONE until the next accepted start; during RUN d holds partial results and is not valid.
REQ-024 Back-to-back: start high in the cycle after DONE (state IDLE) SHALL be accepted; minimum issue interval is NSLICE+1 cycles.

Reset
REQ-025 rst=1 SHALL immediately, regardless of clk, force state IDLE, idx 0, running borrow 0, d=0, bout=0, ovf=0, done=0, busy=0.
REQ-026 Reset during RUN SHALL abort the operation with no done pulse; the first edge after release with start=1 SHALL begin a fresh operation.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and default WIDTH/SLICE constants.
REQ-028 The per-cycle slice SHALL be one sub-module, sub_slice_sel: inputs x[SLICE], y[SLICE], sel; outputs diff[SLICE], bo; contains both borrow-0 and borrow-1 ripple chains plus the select mux, purely combinational.
REQ-029 csel_sub_seq SHALL instantiate exactly one sub_slice_sel, time-multiplexed by idx.

Verification
REQ-030 a=0x1234, b=0x0234, bin=0, start one cycle -> done 4 edges later, d=0x1000, bout=0, ovf=0, busy high for 5 cycles.
REQ-031 a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0.
REQ-032 a=0x8000, b=0x0001, bin=0 -> d=0x7FFF, bout=0, ovf=1; a=0x0005, b=0x0005, bin=1 -> d=0xFFFF, bout=1, ovf=0.
REQ-033 Start with a=0x00FF, b=0x000F, then pulse start with a=0xFFFF, b=0x0000 two cycles later -> single done, d=0x00F0; second request ignored.
REQ-034 Assert rst two cycles into RUN -> outputs 0 immediately, no done; after release, a=0x0010, b=0x0001 -> d=0x000F after 4 edges.
REQ-035 Random a/b/bin, 1000 back-to-back ops at interval 5 -> every done matches reference a-b-bin, bout, ovf.

Source files
------------

// File: rtl/csel_sub_seq_pkg.sv
// Shared FSM encoding and default geometry for the serial
// borrow-select subtractor.
package csel_sub_seq_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SLICE = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/csel_sub_seq_slice.sv
// One SLICE-bit subtract stage: both borrow-in cases are rippled in
// parallel and the incoming borrow picks the result.
module sub_slice_sel #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             sel,
   output logic [SLICE-1:0] diff,
   output logic             bo
);

   logic [SLICE-1:0] w_d0;
   logic [SLICE-1:0] w_d1;
   logic [SLICE:0]   w_b0;
   logic [SLICE:0]   w_b1;

   always_comb begin
      w_d0 = '0;
      w_d1 = '0;
      w_b0 = '0;
      w_b1 = '0;
      w_b1[0] = 1'b1;
      for (int i = 0; i < SLICE; i++) begin
         w_d0[i]   = x[i] ^ y[i] ^ w_b0[i];
         w_b0[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b0[i]);
         w_d1[i]   = x[i] ^ y[i] ^ w_b1[i];
         w_b1[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b1[i]);
      end
   end

   assign diff = sel ? w_d1 : w_d0;
   assign bo   = sel ? w_b1[SLICE] : w_b0[SLICE];

endmodule

// File: rtl/csel_sub_seq.sv
// Serial subtractor: one SLICE-wide borrow-select stage reused over
// NSLICE cycles, producing a - b - bin with borrow-out and overflow.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | waiting for start; last result held on d/bout/ovf
//   ST_RUN  | one slice per edge, running borrow chains slices
//   ST_DONE | result valid, done pulse, back to idle next edge
module csel_sub_seq
   import csel_sub_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_borrow;
   logic [IW-1:0]    r_idx;
   logic [SLICE-1:0] w_x;
   logic [SLICE-1:0] w_y;
   logic [SLICE-1:0] w_diff;
   logic             w_bo;
   logic             w_last;

   assign w_x    = r_a[r_idx*SLICE +: SLICE];
   assign w_y    = r_b[r_idx*SLICE +: SLICE];
   assign w_last = (r_idx == IW'(NSLICE - 1));

   sub_slice_sel #(.SLICE(SLICE)) u_slice (
      .x    (w_x),
      .y    (w_y),
      .sel  (r_borrow),
      .diff (w_diff),
      .bo   (w_bo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_IDLE: if (start) w_next = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (w_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_borrow <= 1'b0;
         r_idx    <= '0;
         d        <= '0;
         bout     <= 1'b0;
         ovf      <= 1'b0;
      end else if (r_state == ST_IDLE && start) begin
         r_a      <= a;
         r_b      <= b;
         r_borrow <= bin;
         r_idx    <= '0;
      end else if (r_state == ST_RUN) begin
         d[r_idx*SLICE +: SLICE] <= w_diff;
         r_borrow <= w_bo;
         r_idx    <= r_idx + IW'(1);
         // overflow uses the MSB of the slice being written, not the stale d
         if (w_last) begin
            r_idx <= '0;
            bout  <= w_bo;
            ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[SLICE-1] != r_a[WIDTH-1]);
         end
      end
   end

endmodule
